// File: rtl/cfu_proto_pkg.sv
// Shared definitions for the CFU command/response protocol: func7 codes, FSM state
// encodings and the function_id packing helper.
package cfu_proto_pkg;

  localparam logic [6:0] FN_CLR_FILT = 7'd0;
  localparam logic [6:0] FN_LOAD8    = 7'd1;
  localparam logic [6:0] FN_LOAD1    = 7'd2;
  localparam logic [6:0] FN_MAC      = 7'd3;
  localparam logic [6:0] FN_CLR_ACC  = 7'd4;
  localparam logic [6:0] FN_SET_OFF  = 7'd5;

  typedef enum logic [3:0] {
    StIdle,
    StClrFilt,
    StFetchF,
    StLoad8,
    StLoad1,
    StSetOff,
    StClrAcc,
    StFetchA,
    StMac,
    StDone
  } seq_state_e;

  typedef enum logic [1:0] {
    PhIdle,
    PhIssue,
    PhWait
  } cmd_phase_e;

  function automatic logic [9:0] func_id(input logic [6:0] func7);
    return {func7, 3'b000};
  endfunction

endpackage

// File: rtl/cfu_cmd_port.sv
// Single-outstanding CFU command engine: registers a command on load, holds it until
// cmd_ready, then waits for the matching response before accepting the next load.
module cfu_cmd_port
  import cfu_proto_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [6:0]  i_func7,
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  output logic        o_idle,
  output logic        o_rsp_fire,
  output logic [31:0] o_rsp_data,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [9:0]  o_cmd_function_id,
  output logic [31:0] o_cmd_inputs_0,
  output logic [31:0] o_cmd_inputs_1,
  input  logic        i_rsp_valid,
  output logic        o_rsp_ready,
  input  logic [31:0] i_rsp_outputs_0
);

  cmd_phase_e  r_phase;
  logic        r_cmd_valid;
  logic        r_rsp_ready;
  logic [9:0]  r_fid;
  logic [31:0] r_in0;
  logic [31:0] r_in1;
  logic        w_rsp_fire;
  logic        w_accept;

  assign w_rsp_fire = r_rsp_ready & i_rsp_valid;
  // A new command may be loaded in the same cycle the previous response completes.
  assign w_accept   = i_load & ((r_phase == PhIdle) | w_rsp_fire);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= PhIdle;
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_fid       <= '0;
      r_in0       <= '0;
      r_in1       <= '0;
    end else if (w_accept) begin
      r_phase     <= PhIssue;
      r_cmd_valid <= 1'b1;
      r_rsp_ready <= 1'b0;
      r_fid       <= func_id(i_func7);
      r_in0       <= i_word0;
      r_in1       <= i_word1;
    end else if ((r_phase == PhIssue) && i_cmd_ready) begin
      r_phase     <= PhWait;
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b1;
    end else if (w_rsp_fire) begin
      r_phase     <= PhIdle;
      r_rsp_ready <= 1'b0;
    end
  end

  assign o_idle            = (r_phase == PhIdle);
  assign o_rsp_fire        = w_rsp_fire;
  assign o_rsp_data        = i_rsp_outputs_0;
  assign o_cmd_valid       = r_cmd_valid;
  assign o_cmd_function_id = r_fid;
  assign o_cmd_inputs_0    = r_in0;
  assign o_cmd_inputs_1    = r_in1;
  assign o_rsp_ready       = r_rsp_ready;

endmodule

// File: rtl/cfu_mac_sequencer.sv
// Drives the CFU filter-buffer MAC through one signed dot product: filter load, offset,
// accumulator clear and one MAC per activation, returning the final accumulator.
module cfu_mac_sequencer
  import cfu_proto_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      input_offset,
  input  logic             flt_valid,
  output logic             flt_ready,
  input  logic [63:0]      flt_data,
  input  logic             act_valid,
  output logic             act_ready,
  input  logic [7:0]       act_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [9:0]       cmd_payload_function_id,
  output logic [31:0]      cmd_payload_inputs_0,
  output logic [31:0]      cmd_payload_inputs_1,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [31:0]      rsp_payload_outputs_0,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  seq_state_e       r_state;
  seq_state_e       w_nxt;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_result;
  logic             r_flt_ready;
  logic             r_act_ready;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_mac_idx;
  logic [LEN_W-4:0] r_f8_left;
  logic [2:0]       r_tail;
  logic [2:0]       r_tail_idx;
  logic [63:0]      r_tail_buf;
  logic [31:0]      r_offset;

  logic             w_load;
  logic [6:0]       w_func7;
  logic [31:0]      w_word0;
  logic [31:0]      w_word1;
  logic             w_finish;
  logic             w_port_idle;
  logic             w_rsp_fire;
  logic [31:0]      w_rsp_data;
  logic             w_start;
  logic             w_flt_fire;
  logic             w_act_fire;
  logic             w_need_flt;
  logic [7:0]       w_tail_byte;

  assign w_start     = start & ~r_busy & w_port_idle;
  assign w_flt_fire  = flt_valid & r_flt_ready;
  assign w_act_fire  = act_valid & r_act_ready;
  assign w_need_flt  = (r_f8_left != '0) || (r_tail != 3'd0);
  assign w_tail_byte = r_tail_buf[{r_tail_idx, 3'b000} +: 8];

  always_comb begin
    w_load   = 1'b0;
    w_func7  = FN_CLR_FILT;
    w_word0  = '0;
    w_word1  = '0;
    w_finish = 1'b0;
    w_nxt    = r_state;
    case (r_state)
      StIdle, StDone: begin
        w_nxt = StIdle;
        if (w_start) begin
          w_load = 1'b1;
          w_nxt  = StClrFilt;
        end
      end
      StClrFilt, StLoad8: begin
        if (w_rsp_fire) begin
          if (w_need_flt) begin
            w_nxt = StFetchF;
          end else begin
            w_load  = 1'b1;
            w_func7 = FN_SET_OFF;
            w_word0 = r_offset;
            w_nxt   = StSetOff;
          end
        end
      end
      StFetchF: begin
        if (w_flt_fire) begin
          w_load = 1'b1;
          if (r_f8_left != '0) begin
            w_func7 = FN_LOAD8;
            w_word0 = flt_data[31:0];
            w_word1 = flt_data[63:32];
            w_nxt   = StLoad8;
          end else begin
            // Tail beat: byte 0 goes out now, the rest from the captured copy.
            w_func7 = FN_LOAD1;
            w_word0 = {flt_data[7:0], 24'h0};
            w_nxt   = StLoad1;
          end
        end
      end
      StLoad1: begin
        if (w_rsp_fire) begin
          w_load = 1'b1;
          if (r_tail_idx < r_tail) begin
            w_func7 = FN_LOAD1;
            w_word0 = {w_tail_byte, 24'h0};
          end else begin
            w_func7 = FN_SET_OFF;
            w_word0 = r_offset;
            w_nxt   = StSetOff;
          end
        end
      end
      StSetOff: begin
        if (w_rsp_fire) begin
          w_load  = 1'b1;
          w_func7 = FN_CLR_ACC;
          w_nxt   = StClrAcc;
        end
      end
      StClrAcc: begin
        if (w_rsp_fire) begin
          if (r_len == '0) begin
            w_finish = 1'b1;
            w_nxt    = StDone;
          end else begin
            w_nxt = StFetchA;
          end
        end
      end
      StFetchA: begin
        if (w_act_fire) begin
          w_load  = 1'b1;
          w_func7 = FN_MAC;
          w_word0 = {{24{act_data[7]}}, act_data};
          w_word1 = {{(32 - LEN_W){1'b0}}, r_mac_idx};
          w_nxt   = StMac;
        end
      end
      StMac: begin
        if (w_rsp_fire) begin
          // r_mac_idx already counts the MAC just completed.
          if (r_mac_idx == r_len) begin
            w_finish = 1'b1;
            w_nxt    = StDone;
          end else begin
            w_nxt = StFetchA;
          end
        end
      end
      default: w_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_flt_ready <= 1'b0;
      r_act_ready <= 1'b0;
      r_len       <= '0;
      r_mac_idx   <= '0;
      r_f8_left   <= '0;
      r_tail      <= '0;
      r_tail_idx  <= '0;
      r_tail_buf  <= '0;
      r_offset    <= '0;
    end else begin
      r_state     <= w_nxt;
      r_flt_ready <= (w_nxt == StFetchF);
      r_act_ready <= (w_nxt == StFetchA);
      r_done      <= w_finish;
      if (w_finish) begin
        r_busy   <= 1'b0;
        r_result <= w_rsp_data;
      end
      if (w_start) begin
        r_busy     <= 1'b1;
        r_len      <= length;
        r_offset   <= input_offset;
        r_f8_left  <= length[LEN_W-1:3];
        r_tail     <= length[2:0];
        r_tail_idx <= 3'd0;
        r_mac_idx  <= '0;
      end
      if ((r_state == StFetchF) && w_flt_fire) begin
        if (r_f8_left != '0) begin
          r_f8_left <= r_f8_left - (LEN_W - 3)'(1);
        end else begin
          r_tail_buf <= flt_data;
          r_tail_idx <= 3'd1;
        end
      end
      if ((r_state == StLoad1) && w_load && (w_func7 == FN_LOAD1)) begin
        r_tail_idx <= r_tail_idx + 3'd1;
      end
      if ((r_state == StFetchA) && w_act_fire) begin
        r_mac_idx <= r_mac_idx + LEN_W'(1);
      end
    end
  end

  cfu_cmd_port u_cmd_port (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_load            (w_load),
    .i_func7           (w_func7),
    .i_word0           (w_word0),
    .i_word1           (w_word1),
    .o_idle            (w_port_idle),
    .o_rsp_fire        (w_rsp_fire),
    .o_rsp_data        (w_rsp_data),
    .o_cmd_valid       (cmd_valid),
    .i_cmd_ready       (cmd_ready),
    .o_cmd_function_id (cmd_payload_function_id),
    .o_cmd_inputs_0    (cmd_payload_inputs_0),
    .o_cmd_inputs_1    (cmd_payload_inputs_1),
    .i_rsp_valid       (rsp_valid),
    .o_rsp_ready       (rsp_ready),
    .i_rsp_outputs_0   (rsp_payload_outputs_0)
  );

  assign flt_ready = r_flt_ready;
  assign act_ready = r_act_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule
